// File: rtl/dec16_rr_arbiter_pkg.sv
// Shared types and helpers for the 16-line round-robin arbiter.
// Defines state encoding, line count and the rotating priority pick.
package dec16_rr_arbiter_pkg;

    localparam int unsigned N_LINES = 16;
    localparam int unsigned IDX_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // First set bit of req at or after ptr, wrapping 15 -> 0.
    // Walking the offsets downwards leaves the smallest offset as the final pick.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_LINES-1:0] req_v,
                                                 input logic [IDX_W-1:0]   ptr_v);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] idx;
        pick = ptr_v;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            idx = ptr_v + IDX_W'(i);
            if (req_v[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dec16_rr_arbiter_dec4to16_al.sv
// Active-low 4-to-16 line decoder: Y is all ones unless en is low,
// in which case only line a is pulled low.
module dec4to16_al
    import dec16_rr_arbiter_pkg::*;
(
    input  logic [IDX_W-1:0]   a,
    input  logic               en,
    output logic [N_LINES-1:0] Y
);

    always_comb begin
        Y = '1;
        if (!en) begin
            Y = ~(N_LINES'(1) << a);
        end
    end

endmodule

// File: rtl/dec16_rr_arbiter.sv
// Round-robin arbiter for 16 requesters, granting through an active-low
// index/enable pair with a mandatory idle cycle between grants.
//
// state | meaning
// IDLE  | no owner; next edge with any request picks a winner
// GRANT | a owns the resource; en low; hold counter running
// GAP   | one idle cycle with en high before arbitrating again
module dec16_rr_arbiter
    import dec16_rr_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_LINES-1:0]   req,
    input  logic                 done,
    output logic [IDX_W-1:0]     a,
    output logic                 en,
    output logic [N_LINES-1:0]   Y,
    output logic                 busy,
    output logic                 timeout
);

    localparam logic       LIMIT_EN  = (HOLD_MAX != 0);
    localparam logic [7:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   a_q, a_d;
    logic               en_q, en_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         hold_q, hold_d;
    logic               timeout_q, timeout_d;

    logic [IDX_W-1:0]   winner;
    logic               limit_hit;
    logic               normal_rel;

    assign winner     = rr_pick(req, ptr_q);
    assign limit_hit  = LIMIT_EN && (hold_q == HOLD_LAST);
    assign normal_rel = done || !req[a_q];

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        en_d      = en_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                en_d = 1'b1;
                if (|req) begin
                    a_d     = winner;
                    en_d    = 1'b0;
                    ptr_d   = winner + IDX_W'(1);
                    hold_d  = 8'd0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                hold_d = hold_q + 8'd1;
                if (normal_rel || limit_hit) begin
                    en_d      = 1'b1;
                    state_d   = ST_GAP;
                    // a coincident voluntary release wins over the hold limit
                    timeout_d = limit_hit && !normal_rel;
                end
            end
            ST_GAP: begin
                en_d    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                en_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            en_q      <= 1'b1;
            ptr_q     <= '0;
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            en_q      <= en_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    dec4to16_al u_dec (
        .a  (a_q),
        .en (en_q),
        .Y  (Y)
    );

    assign a       = a_q;
    assign en      = en_q;
    assign busy    = (state_q == ST_GRANT);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_dec16_rr_arbiter.sv
// Scoreboard bench for dec16_rr_arbiter: a driver advances an ownership
// model per edge and queues expected outputs; a monitor compares them.
module tb_dec16_rr_arbiter;

    localparam int HOLD = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [3:0]  a;
    logic        en;
    logic [15:0] Y;
    logic        busy;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  a;
        logic        en;
        logic [15:0] y;
        logic        busy;
        logic        to;
    } exp_t;

    exp_t exp_q[$];

    // model: who owns the resource, whether we are in the enforced idle cycle
    int   owner    = -1;
    bit   in_gap   = 0;
    int   last_a   = 0;
    int   next_pos = 0;
    int   held     = 0;
    bit   to_pulse = 0;

    dec16_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .a       (a),
        .en      (en),
        .Y       (Y),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge(input bit r, input logic [15:0] rq, input bit d);
        if (!r) begin
            owner = -1; in_gap = 0; last_a = 0; next_pos = 0; held = 0; to_pulse = 0;
        end else if (in_gap) begin
            in_gap   = 0;
            to_pulse = 0;
        end else if (owner >= 0) begin
            bit vol;
            bit lim;
            held++;
            vol = d || !rq[owner];
            lim = (HOLD > 0) && (held == HOLD);
            to_pulse = 0;
            if (vol || lim) begin
                to_pulse = lim && !vol;
                owner    = -1;
                in_gap   = 1;
            end
        end else begin
            to_pulse = 0;
            if (rq != 16'h0) begin
                for (int k = 0; k < 16; k++) begin
                    int cand;
                    cand = (next_pos + k) % 16;
                    if (rq[cand] && owner < 0) owner = cand;
                end
                last_a   = owner;
                next_pos = (owner + 1) % 16;
                held     = 0;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.a    = 4'(last_a);
        e.en   = (owner < 0);
        e.y    = (owner < 0) ? 16'hFFFF : ~(16'h1 << owner);
        e.busy = (owner >= 0);
        e.to   = to_pulse;
        return e;
    endfunction

    task automatic step(input bit r, input logic [15:0] rq, input bit d);
        rst_n = r;
        req   = rq;
        done  = d;
        @(posedge clk);
        model_edge(r, rq, d);
        exp_q.push_back(model_out());
        #2;
    endtask

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, want);
        end
    endtask

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                int   lows;
                e = exp_q.pop_front();
                cmp("a",       16'(a),       16'(e.a));
                cmp("en",      16'(en),      16'(e.en));
                cmp("Y",       Y,            e.y);
                cmp("busy",    16'(busy),    16'(e.busy));
                cmp("timeout", 16'(timeout), 16'(e.to));
                lows = 0;
                for (int b = 0; b < 16; b++) if (!Y[b]) lows++;
                cmp("y_onehot", 16'(lows > 1), 16'(0));
            end
        end
    end

    initial begin
        int wait_cyc;
        rst_n = 1'b0; req = '0; done = 1'b0;
        #2;

        // reset with all requests up
        step(0, 16'hFFFF, 0);
        step(0, 16'hFFFF, 0);

        // single requester, release by done, re-grant
        step(1, 16'h0020, 0);
        step(1, 16'h0020, 0);
        step(1, 16'h0020, 1);
        for (int i = 0; i < 4; i++) step(1, 16'h0020, 0);
        step(1, 16'h0020, 1);
        step(1, 16'h0000, 0);
        step(1, 16'h0000, 0);

        // wrap between 0 and 15
        for (int i = 0; i < 14; i++) step(1, 16'h8001, (i % 3) == 1);
        step(1, 16'h0000, 0);
        step(1, 16'h0000, 0);

        // hold limit reached, then done coinciding with the limit
        for (int i = 0; i < 8; i++) step(1, 16'h0100, 0);
        for (int i = 0; i < 3; i++) step(1, 16'h0000, 0);
        step(1, 16'h0100, 0);
        for (int i = 0; i < 3; i++) step(1, 16'h0100, 0);
        step(1, 16'h0100, 1);
        for (int i = 0; i < 3; i++) step(1, 16'h0000, 0);

        // withdrawal of 3 while 9 asks
        step(1, 16'h0008, 0);
        step(1, 16'h0008, 0);
        for (int i = 0; i < 4; i++) step(1, 16'h0200, 0);
        step(1, 16'h0200, 1);
        for (int i = 0; i < 3; i++) step(1, 16'h0000, 0);

        // reset in the middle of a grant to 12
        step(1, 16'h1000, 0);
        step(1, 16'h1000, 0);
        step(0, 16'h1001, 0);
        step(1, 16'h1001, 0);
        step(1, 16'h1001, 1);
        for (int i = 0; i < 4; i++) step(1, 16'h1001, 0);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            logic [15:0] rq;
            bit          d;
            bit          r;
            rq = 16'($urandom);
            case ($urandom_range(3))
                0: rq = 16'h0;
                1: rq = rq & 16'($urandom) & 16'($urandom);
                default: ;
            endcase
            d = ($urandom_range(4) == 0);
            r = ($urandom_range(99) != 0);
            step(r, rq, d);
        end
        step(1, 16'h0000, 0);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        cmp("drain", 16'(exp_q.size()), 16'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
